// File: rtl/uart_host_sched.sv
// uart_host_sched: drives the UART core's strobe interface on behalf of
// NUM_REQ transmit requesters (round-robin, gated on TXRDY) and one receive
// consumer (bytes drained into a one-entry holding register with error flags).
// Every output comes from a flop. After each strobe, HOLDOFF cycles follow with
// all strobes high. The last of those cycles already evaluates the next
// decision, so successive strobes are 1+HOLDOFF cycles apart.

module uart_host_sched #(
    parameter int NUM_REQ     = 4,
    parameter int RX_PRIORITY = 1,
    parameter int HOLDOFF     = 3
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [7:0]           rx_data,
    output logic [2:0]           rx_err,
    output logic                 busy,
    output logic                 uart_csn,
    output logic                 uart_wen,
    output logic                 uart_oen,
    output logic [7:0]           uart_data_in,
    input  logic [7:0]           uart_data_out,
    input  logic                 uart_txrdy,
    input  logic                 uart_rxrdy,
    input  logic                 uart_parity_err,
    input  logic                 uart_framing_err,
    input  logic                 uart_overflow
);

    localparam int                 PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]   PTR_INIT  = PTR_W'(NUM_REQ - 1);
    localparam logic [3:0]         HOLD_INIT = 4'(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TX_WR = 2'd1,
        RX_RD = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 csn_q, csn_d;
    logic                 wen_q, wen_d;
    logic                 oen_q, oen_d;
    logic [7:0]           data_in_q, data_in_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic [2:0]           rx_err_q, rx_err_d;
    logic                 busy_q, busy_d;

    logic                 tx_found;
    logic [PTR_W-1:0]     tx_sel;
    logic [PTR_W-1:0]     scan_idx;
    logic [7:0]           sel_byte;
    logic                 rx_cand;
    logic                 tx_cand;
    logic                 decide;

    // Round-robin search: first pending requester after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        tx_found = 1'b0;
        tx_sel   = rr_ptr_q;
        scan_idx = rr_ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!tx_found && req_valid[scan_idx]) begin
                tx_found = 1'b1;
                tx_sel   = scan_idx;
            end
        end
    end

    // Byte of the selected requester, picked with constant slices.
    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tx_sel == PTR_W'(i)) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    assign rx_cand = uart_rxrdy & ~rx_valid_q;
    assign tx_cand = tx_found & uart_txrdy;

    // Next-state and registered-output logic for the strobe sequencer and RX holding register.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        csn_d       = 1'b1;
        wen_d       = 1'b1;
        oen_d       = 1'b1;
        data_in_d   = data_in_q;
        req_ready_d = '0;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;
        decide      = 1'b0;

        case (state_q)
            IDLE: begin
                decide = 1'b1;
            end
            TX_WR, RX_RD: begin
                state_d = HOLD;
                cnt_d   = HOLD_INIT;
            end
            HOLD: begin
                if (cnt_q <= 4'd1) begin
                    decide = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (decide) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            if (rx_cand && (!tx_cand || (RX_PRIORITY != 0))) begin
                state_d = RX_RD;
                csn_d   = 1'b0;
                oen_d   = 1'b0;
            end else if (tx_cand) begin
                state_d     = TX_WR;
                csn_d       = 1'b0;
                wen_d       = 1'b0;
                data_in_d   = sel_byte;
                req_ready_d = NUM_REQ'(1) << tx_sel;
                rr_ptr_d    = tx_sel;
            end
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (state_q == RX_RD) begin
            rx_valid_d = 1'b1;
            rx_data_d  = uart_data_out;
            rx_err_d   = {uart_overflow, uart_framing_err, uart_parity_err};
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset returns the strobes high at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PTR_INIT;
            cnt_q       <= 4'd0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            data_in_q   <= 8'h00;
            req_ready_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_err_q    <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            data_in_q   <= data_in_d;
            req_ready_q <= req_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            busy_q      <= busy_d;
        end
    end

    assign uart_csn     = csn_q;
    assign uart_wen     = wen_q;
    assign uart_oen     = oen_q;
    assign uart_data_in = data_in_q;
    assign req_ready    = req_ready_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign rx_err       = rx_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_host_sched.sv
// tb_uart_host_sched: scoreboard bench for uart_host_sched with default parameters.
// Expected TX grants and RX captures are queued when stimulus is applied and
// compared when the DUT produces them.

module tb_uart_host_sched;

    localparam int NUM_REQ = 4;
    localparam int HOLDOFF = 3;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } tx_exp_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] err;
    } rx_exp_t;

    logic                 CLK = 1'b0;
    logic                 RESET_N;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [7:0]           rx_data;
    logic [2:0]           rx_err;
    logic                 busy;
    logic                 uart_csn, uart_wen, uart_oen;
    logic [7:0]           uart_data_in;
    logic [7:0]           uart_data_out;
    logic                 uart_txrdy, uart_rxrdy;
    logic                 uart_parity_err, uart_framing_err, uart_overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic prev_strobe = 1'b0;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    uart_host_sched #(.NUM_REQ(NUM_REQ), .RX_PRIORITY(1), .HOLDOFF(HOLDOFF)) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .rx_data          (rx_data),
        .rx_err           (rx_err),
        .busy             (busy),
        .uart_csn         (uart_csn),
        .uart_wen         (uart_wen),
        .uart_oen         (uart_oen),
        .uart_data_in     (uart_data_in),
        .uart_data_out    (uart_data_out),
        .uart_txrdy       (uart_txrdy),
        .uart_rxrdy       (uart_rxrdy),
        .uart_parity_err  (uart_parity_err),
        .uart_framing_err (uart_framing_err),
        .uart_overflow    (uart_overflow)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Strobe protocol monitor: never back-to-back, csn always accompanies exactly one of wen/oen.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_strobe = 1'b0;
        end else begin
            if (!uart_csn || !uart_wen || !uart_oen) begin
                total++;
                if (prev_strobe || uart_csn || (uart_wen == uart_oen)) begin
                    bad++;
                    $display("[TB] FAIL strobe_rule at cyc %0d: csn/wen/oen=%b%b%b prev=%0b want one strobe, not back-to-back",
                             cyc, uart_csn, uart_wen, uart_oen, prev_strobe);
                end
            end
            prev_strobe = !uart_csn;
        end
    end

    task automatic test_reset;
        RESET_N          = 1'b0;
        req_valid        = '0;
        req_data         = '0;
        rx_ready         = 1'b0;
        uart_data_out    = 8'h00;
        uart_txrdy       = 1'b0;
        uart_rxrdy       = 1'b0;
        uart_parity_err  = 1'b0;
        uart_framing_err = 1'b0;
        uart_overflow    = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({uart_csn, uart_wen, uart_oen, busy, rx_valid} !== 5'b11100) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=11100", {uart_csn, uart_wen, uart_oen, busy, rx_valid});
        end
        total++;
        if ({uart_data_in, req_ready, rx_data, rx_err} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_data got data_in=%h req_ready=%b rx_data=%h rx_err=%b want all zero",
                     uart_data_in, req_ready, rx_data, rx_err);
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        total++;
        if ({uart_csn, uart_wen, uart_oen, busy} !== 4'b1110) begin
            bad++;
            $display("[TB] FAIL reset_release got=%b want=1110", {uart_csn, uart_wen, uart_oen, busy});
        end
    endtask

    task automatic test_reset_mid_tx;
        int n;
        tx_exp_t e;
        req_data[23:16] = 8'h77;
        req_valid       = 4'b0100;
        uart_txrdy      = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (uart_csn && n < 20);
        total++;
        if (uart_csn !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midtx_strobe got csn=%b want=0 within 20 cycles", uart_csn);
        end
        #1 RESET_N = 1'b0;
        #1;
        total++;
        if ({uart_csn, uart_wen, uart_oen, req_ready} !== {3'b111, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL midtx_async got csn/wen/oen=%b%b%b req_ready=%b want 111/0000",
                     uart_csn, uart_wen, uart_oen, req_ready);
        end
        req_valid = '0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        total++;
        if ({busy, req_ready} !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL midtx_idle got busy=%b req_ready=%b want 0/0000", busy, req_ready);
        end
        // Pointer back at NUM_REQ-1: with 0 and 3 pending, 0 must win.
        req_data[7:0]   = 8'h11;
        req_data[31:24] = 8'h99;
        req_valid       = 4'b1001;
        tx_q.push_back('{idx: 0, data: 8'h11});
        n = 0;
        do begin @(negedge CLK); n++; end while (req_ready == '0 && n < 20);
        req_valid = '0;
        if (tx_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL midtx_sb got empty queue want entry");
        end else begin
            e = tx_q.pop_front();
            total++;
            if (req_ready !== (4'b0001 << e.idx) || uart_data_in !== e.data) begin
                bad++;
                $display("[TB] FAIL midtx_rrptr got req_ready=%b data=%h want %b/%h",
                         req_ready, uart_data_in, 4'b0001 << e.idx, e.data);
            end
        end
        repeat (HOLDOFF + 2) @(negedge CLK);
    endtask

    task automatic test_single;
        int n;
        tx_exp_t e;
        req_data[15:8] = 8'hA5;
        req_valid      = 4'b0010;
        uart_txrdy     = 1'b1;
        tx_q.push_back('{idx: 1, data: 8'hA5});
        n = 0;
        do begin @(negedge CLK); n++; end while (req_ready == '0 && n < 20);
        req_valid = '0;
        e = tx_q.pop_front();
        total++;
        if ({uart_csn, uart_wen, uart_oen} !== 3'b001 || req_ready !== (4'b0001 << e.idx) || uart_data_in !== e.data) begin
            bad++;
            $display("[TB] FAIL single_grant got csn/wen/oen=%b%b%b req_ready=%b data=%h want 001/%b/%h",
                     uart_csn, uart_wen, uart_oen, req_ready, uart_data_in, 4'b0001 << e.idx, e.data);
        end
        for (int h = 0; h < HOLDOFF; h++) begin
            @(negedge CLK);
            total++;
            if ({uart_csn, uart_wen, uart_oen, req_ready} !== 7'b1110000) begin
                bad++;
                $display("[TB] FAIL single_hold%0d got csn/wen/oen=%b%b%b req_ready=%b want 111/0000",
                         h, uart_csn, uart_wen, uart_oen, req_ready);
            end
        end
        @(negedge CLK);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin;
        int n;
        int last;
        tx_exp_t e;
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N   = 1'b1;
        @(negedge CLK);
        req_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        req_valid  = 4'b1111;
        uart_txrdy = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tx_q.push_back('{idx: g % NUM_REQ, data: 8'hC0 | 8'(g % NUM_REQ)});
        end
        last = -1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            do begin @(negedge CLK); n++; end while (req_ready == '0 && n < 20);
            e = tx_q.pop_front();
            total++;
            if (req_ready !== (4'b0001 << e.idx) || uart_data_in !== e.data) begin
                bad++;
                $display("[TB] FAIL rr_grant%0d got req_ready=%b data=%h want %b/%h",
                         g, req_ready, uart_data_in, 4'b0001 << e.idx, e.data);
            end
            if (last >= 0) begin
                total++;
                if (cyc - last !== 1 + HOLDOFF) begin
                    bad++;
                    $display("[TB] FAIL rr_spacing%0d got=%0d want=%0d", g, cyc - last, 1 + HOLDOFF);
                end
            end
            last = cyc;
        end
        req_valid = '0;
        repeat (HOLDOFF + 2) @(negedge CLK);
    endtask

    task automatic test_txrdy_gate;
        int n;
        int viol;
        tx_exp_t e;
        uart_txrdy = 1'b0;
        req_valid  = 4'b1111;
        viol = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (!uart_wen || req_ready != '0) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("[TB] FAIL txrdy_hold got %0d strobe/grant cycles want 0", viol);
        end
        uart_txrdy = 1'b1;
        tx_q.push_back('{idx: 1, data: 8'hC1});
        n = 0;
        do begin @(negedge CLK); n++; end while (req_ready == '0 && n < 20);
        req_valid = '0;
        total++;
        if (n !== 1) begin
            bad++;
            $display("[TB] FAIL txrdy_latency got=%0d want=1", n);
        end
        e = tx_q.pop_front();
        total++;
        if (req_ready !== (4'b0001 << e.idx) || uart_data_in !== e.data) begin
            bad++;
            $display("[TB] FAIL txrdy_grant got req_ready=%b data=%h want %b/%h",
                     req_ready, uart_data_in, 4'b0001 << e.idx, e.data);
        end
        repeat (HOLDOFF + 2) @(negedge CLK);
    endtask

    task automatic test_rx_priority;
        int oen_at;
        int wen_at;
        bit got_rx;
        tx_exp_t e;
        rx_exp_t r;
        uart_data_out    = 8'h3C;
        uart_parity_err  = 1'b1;
        uart_framing_err = 1'b0;
        uart_overflow    = 1'b0;
        rx_q.push_back('{data: 8'h3C, err: 3'b001});
        tx_q.push_back('{idx: 0, data: 8'hC0});
        req_valid  = 4'b0001;
        uart_txrdy = 1'b1;
        uart_rxrdy = 1'b1;
        oen_at = -1;
        wen_at = -1;
        got_rx = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (!uart_oen && oen_at < 0) begin
                oen_at     = cyc;
                uart_rxrdy = 1'b0;
            end
            if (!uart_wen && wen_at < 0) begin
                wen_at    = cyc;
                req_valid = '0;
                e = tx_q.pop_front();
                total++;
                if (req_ready !== (4'b0001 << e.idx) || uart_data_in !== e.data) begin
                    bad++;
                    $display("[TB] FAIL rxpri_tx got req_ready=%b data=%h want %b/%h",
                             req_ready, uart_data_in, 4'b0001 << e.idx, e.data);
                end
            end
            if (rx_valid && !got_rx) begin
                got_rx   = 1'b1;
                rx_ready = 1'b1;
                r = rx_q.pop_front();
                total++;
                if (rx_data !== r.data || rx_err !== r.err) begin
                    bad++;
                    $display("[TB] FAIL rxpri_data got %h/%b want %h/%b", rx_data, rx_err, r.data, r.err);
                end
            end else begin
                rx_ready = 1'b0;
            end
        end
        uart_parity_err = 1'b0;
        total++;
        if (oen_at < 0 || wen_at - oen_at !== 1 + HOLDOFF || !got_rx) begin
            bad++;
            $display("[TB] FAIL rxpri_order got oen_at=%0d wen_at=%0d rx=%0b want wen %0d after oen, rx captured",
                     oen_at, wen_at, got_rx, 1 + HOLDOFF);
        end
    endtask

    task automatic test_rx_backpressure;
        int n;
        int viol;
        rx_exp_t r;
        uart_data_out    = 8'h5A;
        uart_overflow    = 1'b1;
        uart_framing_err = 1'b1;
        uart_parity_err  = 1'b0;
        rx_q.push_back('{data: 8'h5A, err: 3'b110});
        uart_rxrdy = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!rx_valid && n < 20);
        r = rx_q.pop_front();
        total++;
        if (rx_valid !== 1'b1 || rx_data !== r.data || rx_err !== r.err) begin
            bad++;
            $display("[TB] FAIL bp_first got v=%b %h/%b want 1 %h/%b", rx_valid, rx_data, rx_err, r.data, r.err);
        end
        uart_data_out    = 8'h81;
        uart_overflow    = 1'b0;
        uart_framing_err = 1'b0;
        rx_q.push_back('{data: 8'h81, err: 3'b000});
        viol = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (!uart_oen || !rx_valid || rx_data !== 8'h5A) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("[TB] FAIL bp_stall got %0d bad cycles want 0", viol);
        end
        rx_ready = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            rx_ready = 1'b0;
            n++;
        end while (uart_oen && n < 20);
        uart_rxrdy = 1'b0;
        total++;
        if (n !== 2) begin
            bad++;
            $display("[TB] FAIL bp_resume got read %0d cycles after rx_ready want 2", n);
        end
        @(negedge CLK);
        r = rx_q.pop_front();
        total++;
        if (rx_valid !== 1'b1 || rx_data !== r.data || rx_err !== r.err) begin
            bad++;
            $display("[TB] FAIL bp_second got v=%b %h/%b want 1 %h/%b", rx_valid, rx_data, rx_err, r.data, r.err);
        end
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
        @(negedge CLK);
        total++;
        if (rx_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_drain got rx_valid=%b want 0", rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_tx();
        test_single();
        test_round_robin();
        test_txrdy_gate();
        test_rx_priority();
        test_rx_backpressure();
        total++;
        if (tx_q.size() != 0 || rx_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_left got tx=%0d rx=%0d want 0/0", tx_q.size(), rx_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_host_sched.md
Name: uart_host_sched

Overview:
- Sequences the UART core's CPU-style strobe interface (CSN/WEN/OEN, DATA_IN/DATA_OUT) on behalf of several on-chip transmit requesters and one receive consumer.
- Arbitrates TX requesters round-robin, gated on TXRDY.
- Drains received bytes on RXRDY into a one-entry holding register, tagged with error flags.
- Sits between the fabric clients and the UART core, on the same system clock.

Parameters:
- NUM_REQ, 4, number of TX requesters (2..8).
- RX_PRIORITY, 1, 1 = a pending RX read wins over TX in IDLE; 0 = TX wins.
- HOLDOFF, 3, idle cycles after each strobe before the next decision, so that TXRDY/RXRDY settle (1..15).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  reset; one clock, reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester byte pending.
- req_data  in  8*NUM_REQ  byte for requester i is bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data while rx_valid=1.
- rx_data  out  8  received byte.
- rx_err  out  3  {overflow, framing, parity} captured with the byte.
- busy  out  1  state != IDLE.
- uart_csn, uart_wen, uart_oen  out  1 each  active-low strobes to the UART.
- uart_data_in  out  8  byte to the UART.
- uart_data_out  in  8  UART read data.
- uart_txrdy, uart_rxrdy, uart_parity_err, uart_framing_err, uart_overflow  in  1 each  UART status.

Behaviour:
- Reset values:
  - uart_csn/wen/oen = 1.
  - uart_data_in = 0, req_ready = 0.
  - rx_valid = 0, rx_data = 0, rx_err = 0.
  - busy = 0, state = IDLE, rr_ptr = NUM_REQ-1, holdoff counter = 0.
- All outputs are registered.
- Reset asserted mid-operation aborts immediately. Strobes return high asynchronously; any byte in flight is lost and no req_ready is issued.
- States:
  - IDLE, TX_WR, RX_RD, HOLD.
- IDLE decision, evaluated every cycle:
  - rx_cand = uart_rxrdy & !rx_valid.
  - tx_cand = |req_valid & uart_txrdy.
  - Both true: RX_PRIORITY selects the winner.
  - Neither true: stay in IDLE.
- TX path:
  - Winner sel = first i with req_valid[i]=1, searching from rr_ptr+1 upward modulo NUM_REQ.
  - On entry to TX_WR, the registered outputs give exactly one cycle of uart_csn=0, uart_wen=0, uart_data_in=req_data[sel], and req_ready[sel]=1 in the same cycle.
  - rr_ptr <= sel.
  - Next state: HOLD.
- RX path:
  - On entry to RX_RD: exactly one cycle of uart_csn=0, uart_oen=0.
  - At the end of that cycle, capture rx_data <= uart_data_out and rx_err <= {uart_overflow, uart_framing_err, uart_parity_err}; set rx_valid <= 1.
  - Next state: HOLD.
- HOLD:
  - Counts HOLDOFF cycles with all strobes high, then returns to IDLE.
  - TX and RX strobes are never asserted in the same cycle.
  - Strobes are never asserted in back-to-back cycles.
- RX handshake:
  - rx_valid & rx_ready clears rx_valid on the next edge.
  - If that clear and a new capture fall on the same edge, the capture wins and rx_valid stays 1 with the new data.
  - While rx_valid=1, no RX read is issued. The UART keeps its byte; overflow is reported by the UART, not by this block.
- Requester contract:
  - req_valid/req_data must stay stable until req_ready.
  - Dropping req_valid before a grant is permitted. That requester is skipped at the next decision.
- Round-robin fairness: with all requesters pending, grants cycle 0,1,...,NUM_REQ-1,0.
- Wrap-around: the search index wraps modulo NUM_REQ. With rr_ptr = NUM_REQ-1 the search starts at 0.

Test Plan:
1. Reset mid-TX_WR (RESET_N low on the strobe cycle) -> csn/wen go high without waiting for CLK; req_ready=0; after release, state=IDLE and rr_ptr=NUM_REQ-1.
2. Single requester: req_valid=4'b0010, req_data[15:8]=8'hA5, txrdy=1 -> one cycle with csn=0, wen=0, data_in=8'hA5 and req_ready=4'b0010; then HOLDOFF=3 cycles with all strobes high.
3. All four requesters valid with txrdy held at 1 -> grant order 0,1,2,3,0; each grant is spaced 1+HOLDOFF cycles apart.
4. txrdy=0 with req_valid=4'b1111 -> no wen strobe and no req_ready for 50 cycles; the first grant follows the rise of txrdy.
5. rxrdy=1 and req_valid=1 together, RX_PRIORITY=1 -> oen strobe precedes wen strobe; rx_data=8'h3C and rx_err=3'b001 when DATA_OUT=8'h3C and parity_err=1.
6. rx_valid=1 with rx_ready=0 while rxrdy=1 -> no oen strobe; after rx_ready pulses, the next read occurs in the following IDLE decision.
